audio_serial_tx: RTL and testbench



---
 rtl/audio_serial_tx.sv | 102 ++++++++++
 tb/tb_audio_serial_tx.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_serial_tx.sv
// I2S transmitter: accepts left/right pairs through valid/ready into a one-pair
// holding register and serialises them MSB first against an internally divided bit clock.
module audio_serial_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int BCLK_DIV   = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] audio_left_in,
    input  logic [DATA_WIDTH-1:0] audio_right_in,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  dac_bclk,
    output logic                  dac_lrclk,
    output logic                  dac_data,
    output logic                  frame_start,
    output logic                  underrun
);

    localparam int FRAME_BITS = 2 * DATA_WIDTH;
    localparam int CW         = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int KW         = $clog2(FRAME_BITS);

    // Handshake: a pair transfers on any clk edge where sample_valid && sample_ready;
    // sample_ready is simply the registered "holding register empty" flag.
    logic [CW-1:0]         div_cnt;
    logic [KW-1:0]         bit_idx;
    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] hold_word;
    logic                  hold_full;
    logic                  div_wrap;
    logic                  fall_edge;
    logic                  frame_load;
    logic                  accept;
    logic [FRAME_BITS-1:0] load_word;

    assign div_wrap     = (div_cnt == CW'(BCLK_DIV - 1));
    assign fall_edge    = div_wrap && dac_bclk;
    assign frame_load   = fall_edge && (bit_idx == '0);
    assign accept       = sample_valid && !hold_full;
    assign sample_ready = !hold_full;

    always_comb begin
        load_word = '0;
        if (hold_full) begin
            load_word = hold_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            hold_word   <= '0;
            hold_full   <= 1'b0;
            dac_bclk    <= 1'b0;
            dac_lrclk   <= 1'b0;
            dac_data    <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            if (div_wrap) begin
                div_cnt  <= '0;
                dac_bclk <= !dac_bclk;
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end

            frame_start <= frame_load;
            underrun    <= frame_load && !hold_full;

            // Serial outputs move only on the bclk falling edge; word select is
            // driven one bit early so it leads the data by one bclk.
            if (fall_edge) begin
                if (bit_idx == KW'(FRAME_BITS - 1)) begin
                    bit_idx <= '0;
                end else begin
                    bit_idx <= bit_idx + KW'(1);
                end
                dac_lrclk <= (bit_idx >= KW'(DATA_WIDTH - 1)) && (bit_idx <= KW'(FRAME_BITS - 2));
                if (bit_idx == '0) begin
                    dac_data  <= load_word[FRAME_BITS-1];
                    shift_reg <= {load_word[FRAME_BITS-2:0], 1'b0};
                end else begin
                    dac_data  <= shift_reg[FRAME_BITS-1];
                    shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                end
            end

            // A load empties a full register; an accept in the same clk can only
            // happen when it was already empty, so the load sends zeros.
            if (frame_load && hold_full) begin
                hold_full <= 1'b0;
            end else if (accept) begin
                hold_full <= 1'b1;
                hold_word <= {audio_left_in, audio_right_in};
            end
        end
    end

endmodule

// File: tb/tb_audio_serial_tx.sv
// Self-checking bench for audio_serial_tx: a time-based reference model checked every
// clk, plus a bclk-rising-edge receiver that pins directed frames to literal words.
module tb_audio_serial_tx;

    localparam int W  = 16;
    localparam int BD = 2;
    localparam int FB = 2 * W;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [W-1:0]  left = '0;
    logic [W-1:0]  right = '0;
    logic          valid = 1'b0;
    logic          sample_ready;
    logic          dac_bclk;
    logic          dac_lrclk;
    logic          dac_data;
    logic          frame_start;
    logic          underrun;

    int checks = 0;
    int errors = 0;

    audio_serial_tx #(.DATA_WIDTH(W), .BCLK_DIV(BD)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .audio_left_in  (left),
        .audio_right_in (right),
        .sample_valid   (valid),
        .sample_ready   (sample_ready),
        .dac_bclk       (dac_bclk),
        .dac_lrclk      (dac_lrclk),
        .dac_data       (dac_data),
        .frame_start    (frame_start),
        .underrun       (underrun)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // Reference model: everything follows from t, the number of clk edges since
    // reset release, plus a queue of accepted pairs awaiting transmission.
    bit            model_on = 1'b0;
    int            t;
    logic [FB-1:0] exp_q[$];
    logic [FB-1:0] m_word;
    logic          m_bclk, m_lr, m_data, m_fs, m_ur, m_ready;

    always @(posedge clk) begin
        int j;
        int k;
        bit was_ready;
        if (!reset_n) begin
            model_on = 1'b1;
            t        = 0;
            exp_q.delete();
            m_word   = '0;
            m_bclk   = 1'b0;
            m_lr     = 1'b0;
            m_data   = 1'b0;
            m_fs     = 1'b0;
            m_ur     = 1'b0;
            m_ready  = 1'b1;
        end else if (model_on) begin
            was_ready = (exp_q.size() == 0);
            t++;
            m_bclk = ((t / BD) % 2) == 1;
            m_fs   = 1'b0;
            m_ur   = 1'b0;
            if (t % (2 * BD) == 0) begin
                j = t / (2 * BD) - 1;
                k = j % FB;
                if (k == 0) begin
                    m_fs = 1'b1;
                    if (exp_q.size() > 0) begin
                        m_word = exp_q.pop_front();
                    end else begin
                        m_word = '0;
                        m_ur   = 1'b1;
                    end
                end
                m_data = m_word[FB-1-k];
                m_lr   = (k >= W - 1) && (k <= FB - 2);
            end
            if (was_ready && valid) exp_q.push_back({left, right});
            m_ready = (exp_q.size() == 0);
        end
    end

    // scoreboard compare, every clk away from the active edge
    always @(negedge clk) begin
        if (model_on) begin
            checks++;
            if ({dac_bclk, dac_lrclk, dac_data, frame_start, underrun, sample_ready} !==
                {m_bclk, m_lr, m_data, m_fs, m_ur, m_ready}) begin
                errors++;
                $display("FAIL model_cmp t=%0d got bclk,lr,data,fs,ur,rdy=%b expected %b", t,
                         {dac_bclk, dac_lrclk, dac_data, frame_start, underrun, sample_ready},
                         {m_bclk, m_lr, m_data, m_fs, m_ur, m_ready});
            end
        end
    end

    // DAC-side receiver: samples data and word select on rising bclk
    logic          prev_bclk = 1'b0;
    logic [FB-1:0] rx_sh = '0;
    logic [FB-1:0] rx_lr = '0;
    logic [FB-1:0] last_word = '0;
    logic [FB-1:0] last_lr = '0;

    always @(negedge clk) begin
        if (dac_bclk === 1'b1 && prev_bclk === 1'b0) begin
            rx_sh = {rx_sh[FB-2:0], dac_data};
            rx_lr = {rx_lr[FB-2:0], dac_lrclk};
        end
        if (frame_start === 1'b1) begin
            last_word = rx_sh;
            last_lr   = rx_lr;
        end
        prev_bclk = dac_bclk;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // driver tasks
    task automatic wait_fs(output logic ur);
        int n = 0;
        ur = 1'b0;
        while (n < 400) begin
            @(negedge clk);
            if (frame_start === 1'b1) break;
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL wait_frame_start timeout got=none expected=pulse");
        end
        ur = underrun;
        #1;
    endtask

    task automatic offer(input logic [W-1:0] l, input logic [W-1:0] r);
        int n = 0;
        left  = l;
        right = r;
        valid = 1'b1;
        while (sample_ready !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            checks++;
            errors++;
            $display("FAIL offer timeout got=ready_low expected=ready_high");
        end
        @(negedge clk);
        valid = 1'b0;
    endtask

    initial begin
        logic ur;

        // reset for 3 clk
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outs", {dac_bclk, dac_lrclk, dac_data, frame_start, underrun, sample_ready}, 6'b000001);
        reset_n = 1'b1;
        @(negedge clk);
        check("bclk_clk1", dac_bclk, 1'b0);
        @(negedge clk);
        check("bclk_rise_clk2", dac_bclk, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("first_fall_fs_ur", {dac_bclk, frame_start, underrun}, 3'b011);

        // single pair
        offer(16'hA5F0, 16'h0F5A);
        wait_fs(ur);
        check("pair_frame_ur", ur, 1'b0);
        wait_fs(ur);
        check("pair_word", last_word, 32'hA5F00F5A);
        check("pair_lrclk", last_lr, 32'h0001FFFE);
        check("underrun_after_pair", ur, 1'b1);
        wait_fs(ur);
        check("underrun_zero_word", last_word, 32'h0);
        check("underrun_repeat", ur, 1'b1);

        // backpressure: A accepted, B held until the register frees
        left  = 16'h1234;
        right = 16'h5678;
        valid = 1'b1;
        @(negedge clk);
        left  = 16'h9ABC;
        right = 16'hDEF0;
        check("ready_drop", sample_ready, 1'b0);
        wait_fs(ur);
        check("a_frame_ur", ur, 1'b0);
        check("ready_return", sample_ready, 1'b1);
        @(negedge clk);
        valid = 1'b0;
        check("ready_b_held", sample_ready, 1'b0);
        wait_fs(ur);
        check("a_word", last_word, 32'h12345678);
        check("b_frame_ur", ur, 1'b0);
        wait_fs(ur);
        check("b_word", last_word, 32'h9ABCDEF0);
        check("after_b_ur", ur, 1'b1);

        // accept exactly on the load clk
        repeat (127) @(negedge clk);
        left  = 16'h7FFF;
        right = 16'h8000;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("load_cycle_fs_ur", {frame_start, underrun}, 2'b11);
        wait_fs(ur);
        check("load_cycle_zero_word", last_word, 32'h0);
        check("next_frame_ur", ur, 1'b0);
        wait_fs(ur);
        check("load_cycle_word", last_word, 32'h7FFF8000);

        // reset mid-frame (k=10) while a pair is held
        offer(16'h1357, 16'h2468);
        repeat (40) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset_outs", {dac_bclk, dac_lrclk, dac_data, frame_start, underrun, sample_ready}, 6'b000001);
        reset_n = 1'b1;
        wait_fs(ur);
        check("post_reset_ur", ur, 1'b1);
        wait_fs(ur);
        check("post_reset_word", last_word, 32'h0);
        check("post_reset_ur2", ur, 1'b1);

        // randomized traffic, checked by the model every clk
        repeat (3000) begin
            @(negedge clk);
            valid = ($urandom_range(0, 9) == 0);
            left  = W'($urandom);
            right = W'($urandom);
        end
        valid = 1'b0;
        repeat (10) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
